// File: rtl/bfs_csr_ctrl.sv
// MMIO control/status block for the BFS servers_system: decodes CCI-P MMIO,
// sequences worklist-service start ahead of BFS start, and captures results.
module bfs_csr_ctrl #(
   parameter logic [127:0] AFU_ID    = 128'h0,
   parameter int           START_GAP = 4,
   parameter logic [63:0]  DFH_VALUE = 64'h1000_0000_0000_1001
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        mmio_wr_valid,
   input  logic [15:0] mmio_wr_addr,
   input  logic [63:0] mmio_wr_data,
   input  logic        mmio_rd_valid,
   input  logic [15:0] mmio_rd_addr,
   input  logic [8:0]  mmio_rd_tid,
   output logic        mmio_rsp_valid,
   output logic [8:0]  mmio_rsp_tid,
   output logic [63:0] mmio_rsp_data,
   output logic        start_worklistServiceMod,
   output logic        start_afuBFS,
   output logic [31:0] setCapacity_worklistServiceMod,
   output logic [63:0] setRd_addr_readNodes,
   output logic [63:0] setRd_addr_readEdges,
   output logic [63:0] setRd_addr_readDistance,
   output logic [63:0] setWr_addr_writeDistance,
   output logic [63:0] setRd_addr_readWorklist,
   output logic [63:0] setWr_addr_writeWorklist,
   input  logic        finish_afuBFS,
   input  logic [63:0] getNodesTchd_afuBFS
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

   state_t      state_q, state_d;
   logic [3:0]  gap_q;
   logic [63:0] cycles_q, nodes_q;
   logic        done_q;
   logic        wl_d, bfs_d, launch, capture, gap_dec, cnt_inc;
   logic        ctrl_wr, go, abort, cfg_ok, busy;
   logic [63:0] rd_data;

   assign ctrl_wr = mmio_wr_valid && (mmio_wr_addr == 16'h0020);
   // abort wins over go when both bits arrive in one write
   assign abort   = ctrl_wr && mmio_wr_data[2];
   assign go      = ctrl_wr && mmio_wr_data[0] && !mmio_wr_data[2];
   assign cfg_ok  = (state_q == IDLE) || (state_q == DONE);
   assign busy    = (state_q == ARM) || (state_q == RUN);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wl_d    = 1'b0;
      bfs_d   = 1'b0;
      launch  = 1'b0;
      capture = 1'b0;
      gap_dec = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE, DONE: if (go) begin
            state_d = ARM;
            wl_d    = 1'b1;
            launch  = 1'b1;
         end
         ARM: begin
            if (abort) state_d = IDLE;
            else if (gap_q == 4'd0) begin
               state_d = RUN;
               bfs_d   = 1'b1;
            end else gap_dec = 1'b1;
         end
         RUN: begin
            if (abort) state_d = IDLE;
            else if (finish_afuBFS) begin
               state_d = DONE;
               capture = 1'b1;
            end else cnt_inc = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         start_worklistServiceMod <= 1'b0;
         start_afuBFS             <= 1'b0;
         gap_q                    <= '0;
         cycles_q                 <= '0;
         nodes_q                  <= '0;
         done_q                   <= 1'b0;
      end else begin
         start_worklistServiceMod <= wl_d;
         start_afuBFS             <= bfs_d;
         if (launch) begin
            gap_q    <= 4'(START_GAP);
            cycles_q <= '0;
            done_q   <= 1'b0;
         end else begin
            if (gap_dec) gap_q <= gap_q - 4'd1;
            if (cnt_inc && (cycles_q != '1)) cycles_q <= cycles_q + 64'd1;
         end
         if (capture) begin
            nodes_q <= getNodesTchd_afuBFS;
            done_q  <= 1'b1;
         end
      end
   end

   // configuration CSRs are frozen while a traversal is in flight
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         setCapacity_worklistServiceMod <= '0;
         setRd_addr_readNodes           <= '0;
         setRd_addr_readEdges           <= '0;
         setRd_addr_readDistance        <= '0;
         setWr_addr_writeDistance       <= '0;
         setRd_addr_readWorklist        <= '0;
         setWr_addr_writeWorklist       <= '0;
      end else if (mmio_wr_valid && cfg_ok) begin
         case (mmio_wr_addr)
            16'h0022: setCapacity_worklistServiceMod <= mmio_wr_data[31:0];
            16'h0024: setRd_addr_readNodes           <= mmio_wr_data;
            16'h0026: setRd_addr_readEdges           <= mmio_wr_data;
            16'h0028: setRd_addr_readDistance        <= mmio_wr_data;
            16'h002A: setWr_addr_writeDistance       <= mmio_wr_data;
            16'h002C: setRd_addr_readWorklist        <= mmio_wr_data;
            16'h002E: setWr_addr_writeWorklist       <= mmio_wr_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      case (mmio_rd_addr)
         16'h0000: rd_data = DFH_VALUE;
         16'h0002: rd_data = AFU_ID[63:0];
         16'h0004: rd_data = AFU_ID[127:64];
         16'h0022: rd_data = {32'd0, setCapacity_worklistServiceMod};
         16'h0024: rd_data = setRd_addr_readNodes;
         16'h0026: rd_data = setRd_addr_readEdges;
         16'h0028: rd_data = setRd_addr_readDistance;
         16'h002A: rd_data = setWr_addr_writeDistance;
         16'h002C: rd_data = setRd_addr_readWorklist;
         16'h002E: rd_data = setWr_addr_writeWorklist;
         16'h0030: rd_data = {60'd0, state_q, busy, done_q};
         16'h0032: rd_data = nodes_q;
         16'h0034: rd_data = cycles_q;
         default:  rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mmio_rsp_valid <= 1'b0;
         mmio_rsp_tid   <= '0;
         mmio_rsp_data  <= '0;
      end else begin
         mmio_rsp_valid <= mmio_rd_valid;
         mmio_rsp_tid   <= mmio_rd_valid ? mmio_rd_tid : 9'd0;
         mmio_rsp_data  <= mmio_rd_valid ? rd_data : 64'd0;
      end
   end

endmodule
